// File: rtl/mode_sequencer_pkg.sv
// Shared types and helpers for the mode sequencer: FSM state encoding and
// the index-to-one-hot decoder used by the channel-enable and LED drivers.
package mode_sequencer_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_GUARD = 1'b1
   } state_t;

   localparam int unsigned MAX_MODES = 16;

   function automatic logic [MAX_MODES-1:0] onehot16(input logic [3:0] idx);
      onehot16      = '0;
      onehot16[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mode_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debouncer and a
// one-cycle pulse on each accepted press (releases are silent).
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;

   // Count runs of synchronised samples that disagree with the accepted level;
   // any agreeing sample (a bounce back) restarts the run.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_pulse <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/mode_sequencer.sv
// N-channel mode selector: debounced next/prev stepping with wrap-around,
// one-hot channel enable, guard interval on each switch, registered output mux.
module mode_sequencer
   import mode_sequencer_pkg::*;
#(
   parameter int unsigned NUM_MODES    = 3,
   parameter int unsigned DEB_CYCLES   = 500000,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter int unsigned IDX_W        = $clog2(NUM_MODES)
) (
   input  logic                 sysclk,
   input  logic                 reset_n,
   input  logic                 btn_next,
   input  logic                 btn_prev,
   input  logic [NUM_MODES-1:0] ch_out,
   output logic [NUM_MODES-1:0] active,
   output logic                 out_final,
   output logic [NUM_MODES-1:0] leds,
   output logic [IDX_W-1:0]     mode_idx
);

   localparam int unsigned      GW   = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MODES - 1);

   state_t               r_state,    w_state_nxt;
   logic [IDX_W-1:0]     r_mode_idx, w_mode_nxt;
   logic [IDX_W-1:0]     r_target,   w_target_nxt;
   logic [GW-1:0]        r_gcnt,     w_gcnt_nxt;
   logic [NUM_MODES-1:0] r_active,   w_active_nxt;
   logic [NUM_MODES-1:0] r_leds,     w_leds_nxt;
   logic                 r_out,      w_out_nxt;
   logic                 w_next_pulse;
   logic                 w_prev_pulse;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .i_clk   (sysclk),
      .i_rst_n (reset_n),
      .i_btn   (btn_next),
      .o_pulse (w_next_pulse)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
      .i_clk   (sysclk),
      .i_rst_n (reset_n),
      .i_btn   (btn_prev),
      .o_pulse (w_prev_pulse)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode_idx;
      w_target_nxt = r_target;
      w_gcnt_nxt   = r_gcnt;
      case (r_state)
         ST_RUN: begin
            if (w_next_pulse && !w_prev_pulse) begin
               w_target_nxt = (r_mode_idx == LAST) ? '0 : r_mode_idx + 1'b1;
               w_state_nxt  = ST_GUARD;
            end else if (w_prev_pulse && !w_next_pulse) begin
               w_target_nxt = (r_mode_idx == '0) ? LAST : r_mode_idx - 1'b1;
               w_state_nxt  = ST_GUARD;
            end
         end
         ST_GUARD: begin
            if (r_gcnt == GW'(GUARD_CYCLES - 1)) begin
               w_mode_nxt  = r_target;
               w_gcnt_nxt  = '0;
               w_state_nxt = ST_RUN;
            end else begin
               w_gcnt_nxt = r_gcnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase

      // Outputs are registered from next-state values so a switch blanks them
      // in the very first guard cycle; out_final stays low for the cycle that
      // leaves guard so only samples taken while enabled are forwarded.
      w_active_nxt = (w_state_nxt == ST_RUN) ?
                     NUM_MODES'(onehot16(4'(w_mode_nxt))) : '0;
      w_leds_nxt   = NUM_MODES'(onehot16(4'((w_state_nxt == ST_RUN) ? w_mode_nxt : w_target_nxt)));
      w_out_nxt    = (r_state == ST_RUN && w_state_nxt == ST_RUN) ? ch_out[r_mode_idx] : 1'b0;
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RUN;
         r_mode_idx <= '0;
         r_target   <= '0;
         r_gcnt     <= '0;
         r_active   <= NUM_MODES'(1);
         r_leds     <= NUM_MODES'(1);
         r_out      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mode_idx <= w_mode_nxt;
         r_target   <= w_target_nxt;
         r_gcnt     <= w_gcnt_nxt;
         r_active   <= w_active_nxt;
         r_leds     <= w_leds_nxt;
         r_out      <= w_out_nxt;
      end
   end

   assign active    = r_active;
   assign leds      = r_leds;
   assign out_final = r_out;
   assign mode_idx  = r_mode_idx;

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised N-channel mode selector for the board-level control system. Debounces front-panel next/previous buttons, steps a mode index with wrap-around in both directions, enables exactly one function channel at a time and muxes that channel's serial output to the board output. On every switch it inserts a guard interval in which no channel is enabled and the output idles low, so a half-finished symbol from the old channel never reaches the new one. Mode LEDs are one-hot.

## Interface
Parameters:
- NUM_MODES, 3: number of function channels; legal range 2..16.
- DEB_CYCLES, 500000: consecutive stable sysclk cycles needed before a button level is accepted; minimum 1.
- GUARD_CYCLES, 16: idle cycles inserted on each mode change; minimum 1.
- IDX_W, $clog2(NUM_MODES): mode index width (derived, do not override).

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_next  in  1  raw async button, advance mode.
- btn_prev  in  1  raw async button, step mode back.
- ch_out  in  NUM_MODES  serial output of each function channel; bit k belongs to mode k.
- active  out  NUM_MODES  one-hot channel enable; all-zero during guard.
- out_final  out  1  registered output of the enabled channel.
- leds  out  NUM_MODES  one-hot display of the current or target mode.
- mode_idx  out  IDX_W  current mode index.

## Operation
- Reset (reset_n low, async): mode_idx=0, state RUN, active=1 (mode 0), leds=1, out_final=0, debouncer levels=0 (released), guard counter=0.
- Each button: 2-flop synchroniser, then debouncer; accepted level changes only after DEB_CYCLES consecutive cycles of the new synchronised value. Any bounce restarts the count.
- Rising edge of an accepted level produces a one-cycle press pulse. Releases produce nothing.
- FSM states: RUN, GUARD.
  - RUN: active=onehot(mode_idx); out_final <= ch_out[mode_idx] each cycle; leds=onehot(mode_idx).
  - RUN + next pulse only: target = mode_idx+1, NUM_MODES-1 wraps to 0 -> GUARD.
  - RUN + prev pulse only: target = mode_idx-1, 0 wraps to NUM_MODES-1 -> GUARD.
  - RUN + both pulses same cycle: ignored, stay in RUN.
  - GUARD: active=0, out_final=0, leds=onehot(target), mode_idx unchanged; counter increments; when counter reaches GUARD_CYCLES-1: mode_idx <= target, counter <= 0 -> RUN.
  - Press pulses arriving in GUARD are dropped, not queued.
- Index arithmetic modulo NUM_MODES; mode_idx never holds a value >= NUM_MODES, including non-power-of-two NUM_MODES.
- Reset asserted in GUARD aborts the switch: returns to mode 0, target discarded.

## Timing
- Button to press pulse: 2 sync cycles + DEB_CYCLES.
- Pulse in cycle p: from p+1 active=0, out_final=0, leds=target.
- Guard lasts exactly GUARD_CYCLES cycles (p+1 .. p+GUARD_CYCLES).
- Cycle p+GUARD_CYCLES+1: state RUN, mode_idx=target, active=onehot(target).
- out_final follows ch_out[mode_idx] with 1-cycle latency in RUN; first valid new-channel sample at p+GUARD_CYCLES+2.
- Min spacing between accepted switches: GUARD_CYCLES+1 cycles, further bounded by debounce.
- All outputs registered; no combinational path from ch_out or buttons to outputs.

## Structure
- Shared package: state encoding constants (ST_RUN, ST_GUARD) and an onehot-from-index function reused by LED drivers.
- One sub-module: btn_debounce (synchroniser + stable-count debouncer + rising-edge pulse, parameter DEB_CYCLES), instantiated twice.
- FSM, index arithmetic, guard counter and output mux live in mode_sequencer.

## Test plan
Bench parameters: NUM_MODES=3, DEB_CYCLES=4, GUARD_CYCLES=3.
- Reset then idle 20 cycles -> mode_idx=0, active=001, leds=001, out_final tracks ch_out[0] one cycle late.
- Clean btn_next hold 10 cycles -> pulse after 6 cycles; guard 3 cycles with active=000, out_final=0, leds=010; then mode_idx=1, active=010.
- btn_prev from mode 0 -> mode_idx=2, leds=100; three btn_next from mode 0 -> back to mode_idx=0 (wrap).
- btn_next bouncing 1/0 every 2 cycles for 20 cycles then steady high -> exactly one switch.
- btn_next and btn_prev rising together (pulses same cycle) -> no switch, mode_idx unchanged; second press during guard -> dropped, only one step.
- reset_n low mid-guard (switching 0->1) -> immediately active=001, mode_idx=0, out_final=0; after release no pending switch.
